// File: rtl/float_to_posit.sv
// -----------------------------------------------------------------------------
// float_to_posit
//   Two-stage pipelined converter from IEEE-754 binary64 to an n-bit posit with
//   es exponent bits, round-to-nearest-even. One conversion per cycle, fixed
//   2-cycle latency, valid/ready on both sides (no skid buffer).
//
//   Stage 1 (decode): classify zero / NaN-Inf / finite, compute scale, split
//                     it into regime k and exponent e, decide saturation.
//   Stage 2 (encode): build regime|e|mantissa, truncate to n-1 bits, RNE,
//                     clamp to maxpos/minpos, two's-complement negate.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   operand_i valid
//   in_ready_o   converter accepts operand_i this cycle (combinational from
//                out_ready_i)
//   operand_i    binary64 operand {sign, exp[10:0], mant[51:0]}
//   out_valid_o  result_o valid
//   out_ready_i  downstream consumes result_o this cycle
//   result_o     n-bit posit, two's-complement
//   flags_o      {nar, saturated, inexact}; only when FLOAT_TO_POSIT_FLAGS_EN
//                is defined
//
// Build option
//   FLOAT_TO_POSIT_FLAGS_EN : adds flags_o and its pipeline registers.
//                             result_o is identical with or without it.
// -----------------------------------------------------------------------------
module float_to_posit #(
    parameter int n        = 16,
    parameter int es       = 1,
    parameter int FP_WIDTH = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [FP_WIDTH-1:0] operand_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
`ifdef FLOAT_TO_POSIT_FLAGS_EN
    output logic [n-1:0]        result_o,
    output logic [2:0]          flags_o
`else
    output logic [n-1:0]        result_o
`endif
);

    localparam int ES_W    = (es > 0) ? es : 1;
    localparam int SH_W    = $clog2(n);
    // Beyond +/-(n-2)*2^es the regime alone no longer fits in n-1 bits.
    localparam int SAT_LIM = (n - 2) << es;
    // Wide enough that the regime shift never pushes mantissa bits out.
    localparam int TOT     = n + es + 54;

    localparam logic [n-2:0] MAXPOS = '1;
    localparam logic [n-2:0] MINPOS = {{(n-2){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Pipeline control
    // -------------------------------------------------------------------------
    logic [2:1] vld_pipe;
    logic       s1_ready, s2_ready, s1_load, s2_load;

    assign s2_ready    = !vld_pipe[2] || out_ready_i;
    assign s1_ready    = !vld_pipe[1] || s2_ready;
    assign in_ready_o  = s1_ready;
    assign out_valid_o = vld_pipe[2];
    assign s1_load     = in_valid_i && s1_ready;
    assign s2_load     = vld_pipe[1] && s2_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            if (s1_ready) vld_pipe[1] <= in_valid_i;
            if (s2_ready) vld_pipe[2] <= vld_pipe[1];
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: decode
    // -------------------------------------------------------------------------
    logic [10:0]     d_exp;
    logic [51:0]     d_mant;
    logic            d_zero, d_nar, d_sub, d_sat_hi, d_sat_lo, d_kneg;
    logic [SH_W-1:0] d_shamt;
    logic [ES_W-1:0] d_e;
    int              scale_c, k_c;

    assign d_exp  = operand_i[62:52];
    assign d_mant = operand_i[51:0];

    always_comb begin
        d_zero   = (d_exp == '0) && (d_mant == '0);
        d_sub    = (d_exp == '0) && (d_mant != '0);
        d_nar    = (d_exp == '1);
        scale_c  = int'(d_exp) - 1023;
        k_c      = scale_c >>> es;                      // floor division
        d_e      = ES_W'(scale_c & ((1 << es) - 1));
        d_kneg   = (k_c < 0);
        // k >= 0: 2'b10 sign-fills ones k places; k < 0: 2'b01 fills zeros.
        d_shamt  = (k_c >= 0) ? SH_W'(k_c) : SH_W'(-k_c - 1);
        d_sat_hi = (scale_c >= SAT_LIM);
        // Subnormals are far below minpos for any legal n/es.
        d_sat_lo = d_sub || (scale_c <= -SAT_LIM);
    end

    logic            s1_sign, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo, s1_kneg;
    logic [SH_W-1:0] s1_shamt;
    logic [ES_W-1:0] s1_e;
    logic [51:0]     s1_mant;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
            s1_kneg   <= 1'b0;
            s1_shamt  <= '0;
            s1_e      <= '0;
            s1_mant   <= '0;
        end else if (s1_load) begin
            s1_sign   <= operand_i[63];
            s1_zero   <= d_zero;
            s1_nar    <= d_nar;
            s1_sat_hi <= d_sat_hi;
            s1_sat_lo <= d_sat_lo;
            s1_kneg   <= d_kneg;
            s1_shamt  <= d_shamt;
            s1_e      <= d_e;
            s1_mant   <= d_mant;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: encode
    // -------------------------------------------------------------------------
    logic signed [TOT-1:0] seed, shifted;
    logic [n-2:0]          mag, mag_f;
    logic [n-1:0]          sum, mag_ext, res_c;
    logic                  guard, sticky, rnd, clamp_hi, clamp_lo;

    always_comb begin
        seed = '0;
        seed[TOT-1 -: 2] = s1_kneg ? 2'b01 : 2'b10;
        for (int i = 0; i < es; i++) seed[TOT-3-i] = s1_e[es-1-i];
        seed[TOT-3-es -: 52] = s1_mant;
    end

    // Arithmetic shift replicates the leading regime bit to grow the regime.
    assign shifted = seed >>> s1_shamt;
    assign mag     = shifted[TOT-1 -: n-1];
    assign guard   = shifted[TOT-n];
    assign sticky  = |shifted[TOT-n-1:0];
    assign rnd     = guard & (sticky | mag[0]);
    assign sum     = {1'b0, mag} + {{(n-1){1'b0}}, rnd};

    always_comb begin
        clamp_lo = s1_sat_lo || (!s1_sat_hi && (sum == '0));
        clamp_hi = !s1_sat_lo && (s1_sat_hi || sum[n-1]);
        mag_f    = clamp_hi ? MAXPOS : (clamp_lo ? MINPOS : sum[n-2:0]);
        mag_ext  = {1'b0, mag_f};
        if (s1_zero)      res_c = '0;
        else if (s1_nar)  res_c = {1'b1, {(n-1){1'b0}}};
        else              res_c = s1_sign ? -mag_ext : mag_ext;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      result_o <= '0;
        else if (s2_load) result_o <= res_c;
    end

`ifdef FLOAT_TO_POSIT_FLAGS_EN
    logic       finite;
    logic [2:0] flg_c;

    assign finite   = !s1_zero && !s1_nar;
    assign flg_c[2] = s1_nar;
    assign flg_c[1] = finite && (clamp_hi || clamp_lo);
    assign flg_c[0] = finite && (clamp_hi || clamp_lo || guard || sticky);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      flags_o <= '0;
        else if (s2_load) flags_o <= flg_c;
    end
`endif

endmodule

// File: tb/tb_float_to_posit.sv
// Scoreboard bench for float_to_posit (n=16, es=1). Expected results come from
// a bit-queue reference model of the posit encoding rules or from constants.
module tb_float_to_posit;
    localparam int N  = 16;
    localparam int ES = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   operand = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  result;
`ifdef FLOAT_TO_POSIT_FLAGS_EN
    logic [2:0]    flags;
`endif

    float_to_posit #(.n(N), .es(ES), .FP_WIDTH(64)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .operand_i  (operand),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
`ifdef FLOAT_TO_POSIT_FLAGS_EN
        .result_o   (result),
        .flags_o    (flags)
`else
        .result_o   (result)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] res;
        logic [2:0]   flg;
        int           acc_cyc;
        bit           chk_lat;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Reference model: spell out regime, exponent and mantissa bit by bit.
    function automatic void model(input logic [63:0] x, output logic [N-1:0] r, output logic [2:0] f);
        int   scale, k, e, p, mag;
        bit   sat, g, st, rnd;
        bit   q[$];
        logic [10:0] ex;
        ex = x[62:52];
        p = 1 << ES;
        sat = 0; g = 0; st = 0; mag = 0;
        if (ex == 0 && x[51:0] == 0) begin r = '0; f = 3'b000; return; end
        if (ex == 11'h7FF) begin r = {1'b1, {(N-1){1'b0}}}; f = 3'b100; return; end
        scale = int'(ex) - 1023;
        if (ex == 0 || scale <= -(N-2)*p) begin
            mag = 1; sat = 1;
        end else if (scale >= (N-2)*p) begin
            mag = 2**(N-1) - 1; sat = 1;
        end else begin
            k = (scale >= 0) ? scale / p : -((-scale + p - 1) / p);
            e = scale - k*p;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int b = ES-1; b >= 0; b--) q.push_back(bit'((e >> b) & 1));
            for (int b = 51; b >= 0; b--) q.push_back(x[b]);
            for (int i = 0; i < N-1; i++) mag = mag*2 + int'(q[i]);
            g = q[N-1];
            for (int i = N; i < q.size(); i++) st |= q[i];
            rnd = g & (st | mag[0]);
            mag += int'(rnd);
            if (mag >= 2**(N-1)) begin mag = 2**(N-1) - 1; sat = 1; end
            if (mag == 0) begin mag = 1; sat = 1; end
        end
        r = x[63] ? N'(-mag) : N'(mag);
        f = {1'b0, sat, sat | g | st};
    endfunction

    task automatic send(input logic [63:0] op, input logic [N-1:0] r, input logic [2:0] f, input bit lat);
        exp_t e;
        int   tries;
        bit   done;
        e.res = r; e.flg = f; e.chk_lat = lat; e.acc_cyc = 0;
        tries = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1;
            operand  = op;
            #1;
            if (in_ready) begin
                e.acc_cyc = cyc;
                @(posedge clk);
                sb.push_back(e);
                done = 1;
            end else begin
                tries++;
                if (tries > 200) begin
                    check("accept_timeout", in_ready, 1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic send_m(input logic [63:0] op, input bit lat);
        logic [N-1:0] r;
        logic [2:0]   f;
        model(op, r, f);
        send(op, r, f, lat);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] x;
        logic [10:0] ex;
        logic [51:0] m;
        x  = {$urandom, $urandom};
        m  = x[51:0];
        ex = 11'(1023 + $urandom_range(0, 70) - 35);
        case ($urandom_range(0, 9))
            0: return x;
            1: begin ex = '1; if ($urandom_range(0, 1) == 0) m = '0; end
            2: begin ex = '0; m = m >> $urandom_range(0, 52); end
            3: m[37:0] = '0;
            default: ;
        endcase
        return {x[63], ex, m};
    endfunction

    // Monitor: pops on every transfer, checks stability while stalled.
    initial begin
        bit           held;
        logic [N-1:0] held_res;
        logic [2:0]   held_flg;
        exp_t         e;
        held = 0; held_res = '0; held_flg = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 0;
                continue;
            end
            if (held) begin
                check("stall_valid", out_valid, 1);
                check("stall_result", result, held_res);
`ifdef FLOAT_TO_POSIT_FLAGS_EN
                check("stall_flags", flags, held_flg);
`endif
            end
            held = out_valid && !out_ready;
            held_res = result;
`ifdef FLOAT_TO_POSIT_FLAGS_EN
            held_flg = flags;
`endif
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
`ifdef FLOAT_TO_POSIT_FLAGS_EN
                    check("flags", flags, e.flg);
`endif
                    if (e.chk_lat) check("latency", cyc - e.acc_cyc, 2);
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0]  d_op  [15] = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000,
                                 64'h3FF8000000000000, 64'h0000000000000000, 64'h8000000000000000,
                                 64'h7FF8000000000000, 64'hFFF0000000000000, 64'h7E37E43C8800759C,
                                 64'hFE37E43C8800759C, 64'h01A56E1FC2F8F359, 64'h0000000000000001,
                                 64'h3FF0008000000000, 64'h3FF0018000000000, 64'h3FF0008000000001};
    logic [N-1:0] d_res [15] = '{16'h4000, 16'hC000, 16'h5000, 16'h4800, 16'h0000, 16'h0000,
                                 16'h8000, 16'h8000, 16'h7FFF, 16'h8001, 16'h0001, 16'h0001,
                                 16'h4000, 16'h4002, 16'h4001};
    logic [2:0]   d_flg [15] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b100, 3'b100, 3'b011, 3'b011, 3'b011, 3'b011,
                                 3'b001, 3'b001, 3'b001};

    initial begin
        exp_t e;
        logic [N-1:0] r;
        logic [2:0]   f;
        int           waited;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef FLOAT_TO_POSIT_FLAGS_EN
        check("rst_flags", flags, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Directed values, back to back
        for (int i = 0; i < 15; i++) send(d_op[i], d_res[i], d_flg[i], 1);
        idle(4);

        // Backpressure: two fill the pipe, the third waits for release
        @(negedge clk);
        out_ready = 1'b0;
        send_m(64'h3FF0000000000000, 0);
        send_m(64'h4000000000000000, 0);
        @(negedge clk);
        in_valid = 1'b1;
        operand  = 64'h3FF8000000000000;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_in_ready_held", in_ready, 0);
        end
        pop_cyc.delete();
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_accept_on_release", in_ready, 1);
        model(64'h3FF8000000000000, r, f);
        e.res = r; e.flg = f; e.chk_lat = 0; e.acc_cyc = cyc;
        @(posedge clk);
        sb.push_back(e);
        idle(5);
        check("bp_drain_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("bp_consecutive_1", pop_cyc[1] - pop_cyc[0], 1);
            check("bp_consecutive_2", pop_cyc[2] - pop_cyc[1], 1);
        end

        // Reset with two items in flight
        @(negedge clk);
        out_ready = 1'b0;
        send_m(64'h4000000000000000, 0);
        send_m(64'hBFF0000000000000, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_in_ready", in_ready, 1);
        check("rst_async_result", result, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("no_stale_output", out_valid, 0);
        end
        send_m(64'h3FF0000000000000, 1);
        idle(4);

        // Randomised traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send_m(rand_op(), 0);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
